// File: rtl/tt_wb_ctrl.sv
// Wishbone classic responder exposing the TinyTapeout project-select chain:
// ID/CTRL/SCRATCH/STATUS registers plus a serial shifter that loads and latches the project address.
module tt_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          SHIFT_DIV = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ctrl_sel_dat_o,
    output logic        ctrl_sel_clk_o,
    output logic        ctrl_sel_latch_o,
    output logic        irq_o
);

    localparam logic [31:0] ID_VALUE = 32'h5454_0305;
    localparam logic [7:0]  DIV_LAST = 8'(SHIFT_DIV - 1);
    localparam logic [3:0]  MSB_IDX  = 4'(ADDR_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic        sdat_q, sdat_d;
    logic        sclk_q, sclk_d;
    logic        latch_q, latch_d;

    logic              ack_q;
    logic [31:0]       rdata_q;
    logic              irq_q;
    logic [ADDR_W-1:0] proj_sel;
    logic              irq_en;
    logic [31:0]       scratch;
    logic [15:0]       count;
    logic              done;
    logic              ovr;

    logic        hit;
    logic        wr_hit;
    logic        busy;
    logic        latch_exit;
    logic        ctrl_wr;
    logic        start;
    logic [1:0]  reg_idx;
    logic [31:0] rd_mux;
    logic        unused_adr;

    assign reg_idx    = wbs_adr_i[3:2];
    assign unused_adr = ^wbs_adr_i[1:0];
    // ~ack_q keeps one request from being acked twice, so back-to-back strobes ack every other cycle.
    assign hit        = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_hit     = hit & wbs_we_i;
    assign busy       = (state_q != IDLE);
    assign latch_exit = (state_q == LATCH) && (div_q == DIV_LAST);
    assign ctrl_wr    = wr_hit && (reg_idx == 2'd1) && (|wbs_sel_i);
    assign start      = ctrl_wr && !busy;

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            2'd0: rd_mux = ID_VALUE;
            2'd1: rd_mux = {busy, irq_en, 30'(proj_sel)};
            2'd2: rd_mux = scratch;
            2'd3: rd_mux = {14'h0, ovr, done, count};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sdat_d  = sdat_q;
        sclk_d  = sclk_q;
        latch_d = latch_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    bit_d   = MSB_IDX;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    sdat_d  = wbs_dat_i[ADDR_W-1];
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        state_d = LATCH;
                        sclk_d  = 1'b0;
                        latch_d = 1'b1;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        sclk_d = 1'b0;
                        sdat_d = proj_sel[bit_q - 4'd1];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    state_d = IDLE;
                    div_d   = '0;
                    latch_d = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (wb_rst_i) begin
            state_q <= IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            sdat_q  <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sdat_q  <= sdat_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            proj_sel <= '0;
            irq_en   <= 1'b0;
            scratch  <= '0;
            count    <= '0;
            done     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            ack_q   <= hit;
            rdata_q <= (hit && !wbs_we_i) ? rd_mux : '0;
            irq_q   <= done & irq_en;
            if (ctrl_wr) begin
                irq_en <= wbs_dat_i[30];
                if (!busy) proj_sel <= wbs_dat_i[ADDR_W-1:0];
                else       ovr      <= 1'b1;
            end
            if (wr_hit && reg_idx == 2'd2) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
            if (wr_hit && reg_idx == 2'd3 && wbs_sel_i[2]) begin
                if (wbs_dat_i[16]) done <= 1'b0;
                if (wbs_dat_i[17]) ovr  <= 1'b0;
            end
            // Placed after the W1C so a completion on the same edge keeps done set.
            if (latch_exit) begin
                done  <= 1'b1;
                count <= count + 16'd1;
            end
        end
    end

    assign wbs_ack_o        = ack_q;
    assign wbs_dat_o        = rdata_q;
    assign ctrl_sel_dat_o   = sdat_q;
    assign ctrl_sel_clk_o   = sclk_q;
    assign ctrl_sel_latch_o = latch_q;
    assign irq_o            = irq_q;

endmodule
